// File: rtl/debug_cmd_sequencer_if.sv
// rtl/debug_cmd_sequencer_if.sv - UART word channel, imem write port and CPU debug/control bundle
interface debug_cmd_sequencer_if #(
  parameter int NREGS = 32
);
  localparam int RA_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  // UART word-level channel
  logic            rx_valid;
  logic [31:0]     rx_data;
  logic            tx_start;
  logic [31:0]     tx_data;
  logic            tx_done;

  // Instruction-memory write port
  logic            imem_we;
  logic [31:0]     imem_addr;
  logic [31:0]     imem_wdata;

  // CPU control and debug read ports
  logic            cpu_rst;
  logic            cpu_enable;
  logic            cpu_halted;
  logic [31:0]     pc_in;
  logic [RA_W-1:0] dbg_reg_addr;
  logic [31:0]     dbg_reg_data;
  logic [31:0]     dbg_mem_addr;
  logic [31:0]     dbg_mem_data;

  logic            busy;

  // Sequencer side
  modport master (
    input  rx_valid, rx_data, tx_done, cpu_halted, pc_in, dbg_reg_data, dbg_mem_data,
    output tx_start, tx_data, imem_we, imem_addr, imem_wdata, cpu_rst, cpu_enable,
           dbg_reg_addr, dbg_mem_addr, busy
  );

  // UART / CPU / memory side
  modport slave (
    output rx_valid, rx_data, tx_done, cpu_halted, pc_in, dbg_reg_data, dbg_mem_data,
    input  tx_start, tx_data, imem_we, imem_addr, imem_wdata, cpu_rst, cpu_enable,
           dbg_reg_addr, dbg_mem_addr, busy
  );
endinterface

// File: rtl/debug_cmd_sequencer.sv
// rtl/debug_cmd_sequencer.sv - UART command sequencer: imem load, run/step, state dump
module debug_cmd_sequencer #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          NREGS      = 32,   // must match the interface NREGS
  parameter int          DMEM_WORDS = 16,
  parameter logic [31:0] HALT_WORD  = 32'h0000_0000,
  parameter logic [31:0] ERR_WORD   = 32'hFFFF_FFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  debug_cmd_sequencer_if.master  bus
);

  localparam int          RA_W      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_DEPTH - 1);
  localparam logic [31:0] NREGS_W   = 32'(NREGS);
  localparam logic [31:0] MEM_END   = 32'(NREGS + DMEM_WORDS);      // index of last memory word
  localparam logic [31:0] LAST_IDX  = 32'(NREGS + DMEM_WORDS + 1);  // index of cycle_cnt word

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_FIN,
    S_RUN,
    S_STEP,
    S_STEP_OFF,
    S_D_RD,
    S_D_LATCH,
    S_D_WAIT,
    S_E_LATCH,
    S_E_WAIT
  } state_t;

  state_t          state_q;
  logic            loaded_q;
  logic [31:0]     cycle_cnt_q;
  logic [31:0]     wr_cnt_q;
  logic [31:0]     idx_q;        // dump word index: 0=pc, 1..NREGS=regs, then mem, then cycle_cnt
  logic            tx_start_q;
  logic [31:0]     tx_data_q;
  logic            imem_we_q;
  logic [31:0]     imem_addr_q;
  logic [31:0]     imem_wdata_q;
  logic            cpu_rst_q;
  logic            cpu_enable_q;
  logic [RA_W-1:0] dbg_reg_addr_q;
  logic [31:0]     dbg_mem_addr_q;

  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.cpu_rst      = cpu_rst_q;
  assign bus.cpu_enable   = cpu_enable_q;
  assign bus.dbg_reg_addr = dbg_reg_addr_q;
  assign bus.dbg_mem_addr = dbg_mem_addr_q;
  assign bus.busy         = (state_q != S_IDLE);

  // Command FSM with all outputs registered; strobes default low every cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      loaded_q       <= 1'b0;
      cycle_cnt_q    <= '0;
      wr_cnt_q       <= '0;
      idx_q          <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_rst_q      <= 1'b1;
      cpu_enable_q   <= 1'b0;
      dbg_reg_addr_q <= '0;
      dbg_mem_addr_q <= '0;
    end else begin
      imem_we_q  <= 1'b0;
      tx_start_q <= 1'b0;

      // Count enabled CPU cycles, sticking at all-ones
      if (cpu_enable_q && (cycle_cnt_q != '1)) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.rx_valid) begin
            case (bus.rx_data[7:0])
              8'h01: begin
                state_q   <= S_LOAD;
                cpu_rst_q <= 1'b1;
                loaded_q  <= 1'b0;
                wr_cnt_q  <= '0;
              end
              8'h02:   state_q <= loaded_q ? S_RUN  : S_E_LATCH;
              8'h03:   state_q <= loaded_q ? S_STEP : S_E_LATCH;
              default: state_q <= S_E_LATCH;
            endcase
          end
        end

        S_LOAD: begin
          if (bus.rx_valid) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= wr_cnt_q;
            imem_wdata_q <= bus.rx_data;
            wr_cnt_q     <= wr_cnt_q + 32'd1;
            // The terminating word is still written; the top address also ends the load
            if ((bus.rx_data == HALT_WORD) || (wr_cnt_q == LAST_ADDR)) begin
              state_q <= S_LOAD_FIN;
            end
          end
        end

        S_LOAD_FIN: begin
          cpu_rst_q   <= 1'b0;
          loaded_q    <= 1'b1;
          cycle_cnt_q <= '0;
          state_q     <= S_IDLE;
        end

        S_RUN: begin
          // Enable stays up until halted is seen; halted on entry means it never rises
          if (bus.cpu_halted) begin
            cpu_enable_q <= 1'b0;
            idx_q        <= '0;
            state_q      <= S_D_RD;
          end else begin
            cpu_enable_q <= 1'b1;
          end
        end

        S_STEP: begin
          if (bus.cpu_halted) begin
            idx_q   <= '0;
            state_q <= S_D_RD;
          end else begin
            cpu_enable_q <= 1'b1;
            state_q      <= S_STEP_OFF;
          end
        end

        S_STEP_OFF: begin
          cpu_enable_q <= 1'b0;
          idx_q        <= '0;
          state_q      <= S_D_RD;
        end

        // Debug read address was set on entry; read data arrives one cycle later
        S_D_RD: state_q <= S_D_LATCH;

        S_D_LATCH: begin
          if (idx_q == 32'd0) begin
            tx_data_q <= bus.pc_in;
          end else if (idx_q <= NREGS_W) begin
            tx_data_q <= bus.dbg_reg_data;
          end else if (idx_q <= MEM_END) begin
            tx_data_q <= bus.dbg_mem_data;
          end else begin
            tx_data_q <= cycle_cnt_q;
          end
          tx_start_q <= 1'b1;
          state_q    <= S_D_WAIT;
        end

        S_D_WAIT: begin
          if (bus.tx_done) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_IDLE;
            end else begin
              // Word idx_q+1 reads reg[idx_q] or mem[idx_q-NREGS]
              if (idx_q < NREGS_W) begin
                dbg_reg_addr_q <= idx_q[RA_W-1:0];
              end else if (idx_q < MEM_END) begin
                dbg_mem_addr_q <= idx_q - NREGS_W;
              end
              idx_q   <= idx_q + 32'd1;
              state_q <= S_D_RD;
            end
          end
        end

        S_E_LATCH: begin
          tx_data_q  <= ERR_WORD;
          tx_start_q <= 1'b1;
          state_q    <= S_E_WAIT;
        end

        S_E_WAIT: begin
          if (bus.tx_done) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// tb/tb_debug_cmd_sequencer.sv - self-checking bench for debug_cmd_sequencer
module tb_debug_cmd_sequencer;

  localparam logic [31:0] ERRW = 32'hFFFF_FFFF;
  localparam int          NTX  = 50;   // 2 + 32 regs + 16 mem words
  localparam int          HUGE = 32'h7FFF_FFFF;

  logic clk;
  logic rst;

  debug_cmd_sequencer_if #(.NREGS(32)) bus ();

  debug_cmd_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment state
  logic [31:0] regs_m [32];
  logic [31:0] mem_m  [16];
  logic [31:0] tx_q [$];
  logic [63:0] wr_q [$];
  logic [31:0] prog_q [$];
  logic [31:0] pc_m = '0;
  int          en_total = 0;
  int          halt_at = HUGE;
  bit          halt_force = 1'b0;
  int          hold_at = -1;
  bit          model_loaded = 1'b0;
  logic [31:0] cnt_m = '0;

  typedef struct {
    logic [31:0] word;
    bit          force_halt;
    int          k;
    int          ntx;
    int          en;
    logic [31:0] last;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Registered debug read ports: data valid one cycle after address
  always @(posedge clk) begin
    bus.dbg_reg_data <= regs_m[bus.dbg_reg_addr];
    bus.dbg_mem_data <= mem_m[bus.dbg_mem_addr[3:0]];
  end

  // CPU model: PC advances by 4 per enabled cycle; halted per test setting
  initial begin
    bus.cpu_halted = 1'b0;
    bus.pc_in = '0;
    forever begin
      @(negedge clk);
      if (bus.cpu_enable) en_total++;
      if (bus.cpu_rst) pc_m = '0;
      else if (bus.cpu_enable) pc_m = pc_m + 32'd4;
      bus.cpu_halted = halt_force || (en_total >= halt_at);
      bus.pc_in = pc_m;
    end
  end

  // UART TX model: captures each started word, answers tx_done after a random delay
  initial begin
    bit pend;
    int cd;
    pend = 1'b0;
    cd = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (pend && cd == 0) begin
        bus.tx_done = 1'b1;
        pend = 1'b0;
      end else if (pend) begin
        cd--;
      end
      if (bus.tx_start) begin
        tx_q.push_back(bus.tx_data);
        if (tx_q.size() != hold_at) begin
          pend = 1'b1;
          cd = $urandom_range(0, 2);
        end
      end
    end
  end

  // Imem write monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.imem_we) wr_q.push_back({bus.imem_addr, bus.imem_wdata});
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] w);
    bus.rx_valid = 1'b1;
    bus.rx_data  = w;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic set_halt(input bit f, input int k);
    halt_force = f;
    halt_at = (k > 0) ? en_total + k : HUGE;
  endtask

  // Issue one command and compare TX words, enabled cycles and CPU control against expectations
  task automatic do_cmd(input logic [31:0] w, input int exp_ntx, input int exp_en,
                        input logic [31:0] exp_last, input string tag);
    int en0;
    int t;
    logic [31:0] pc0;
    logic [31:0] ew;
    repeat (2) @(negedge clk);
    en0 = en_total;
    pc0 = pc_m;
    tx_q.delete();
    wr_q.delete();
    send_word(w);
    t = 0;
    while (bus.busy && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " busy_end"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " tx_count"}, 32'(tx_q.size()), 32'(exp_ntx));
    chk({tag, " en_cycles"}, 32'(en_total - en0), 32'(exp_en));
    chk({tag, " cpu_rst"}, {31'd0, bus.cpu_rst}, {31'd0, !model_loaded});
    chk({tag, " no_writes"}, 32'(wr_q.size()), 32'd0);
    for (int i = 0; i < exp_ntx && i < tx_q.size(); i++) begin
      if (exp_ntx == 1) ew = ERRW;
      else if (i == 0) ew = pc0 + 32'(4 * exp_en);
      else if (i <= 32) ew = regs_m[i-1];
      else if (i <= 48) ew = mem_m[i-33];
      else ew = exp_last;
      chk($sformatf("%s word%0d", tag, i), tx_q[i], ew);
    end
    if (exp_ntx > 1) cnt_m = exp_last;
  endtask

  // LOAD of prog_q: writes stop at HALT word or the last address
  task automatic do_load(input string tag);
    logic [31:0] tmp;
    int n;
    n = 0;
    while (n < prog_q.size() && n < 256) begin
      n++;
      if (prog_q[n-1] == 32'h0) break;
    end
    wr_q.delete();
    tx_q.delete();
    tmp = $urandom();
    send_word({tmp[31:8], 8'h01});
    for (int i = 0; i < prog_q.size(); i++) begin
      send_word(prog_q[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk({tag, " wr_count"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      chk($sformatf("%s wr%0d", tag, i), wr_q[i][63:32], 32'(i));
      chk($sformatf("%s wd%0d", tag, i), wr_q[i][31:0], prog_q[i]);
    end
    chk({tag, " cpu_rst"}, {31'd0, bus.cpu_rst}, 32'd0);
    chk({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " no_tx"}, 32'(tx_q.size()), 32'd0);
    model_loaded = 1'b1;
    cnt_m = '0;
  endtask

  initial begin
    logic [31:0] tmp;
    int t;
    int kind;
    int k;

    tbl[0]  = '{32'h0000_0002, 1'b0, 0, 1, 0, ERRW};
    tbl[1]  = '{32'h0000_0003, 1'b0, 0, 1, 0, ERRW};
    tbl[2]  = '{32'h1234_5655, 1'b0, 0, 1, 0, ERRW};
    tbl[3]  = '{32'hFFFF_FF00, 1'b0, 0, 1, 0, ERRW};
    tbl[4]  = '{32'h0000_0002, 1'b0, 10, NTX, 10, 32'd10};
    tbl[5]  = '{32'h0000_0003, 1'b0, 0, NTX, 1, 32'd11};
    tbl[6]  = '{32'h0000_0002, 1'b1, 0, NTX, 0, 32'd11};
    tbl[7]  = '{32'h0000_0003, 1'b1, 0, NTX, 0, 32'd11};
    tbl[8]  = '{32'hABCD_0003, 1'b0, 0, NTX, 1, 32'd12};
    tbl[9]  = '{32'h0000_0107, 1'b0, 0, 1, 0, ERRW};
    tbl[10] = '{32'h0000_0002, 1'b0, 3, NTX, 3, 32'd15};

    for (int i = 0; i < 32; i++) regs_m[i] = $urandom();
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom();

    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
    chk("reset cpu_enable", {31'd0, bus.cpu_enable}, 32'd0);
    chk("reset tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("reset tx_data", bus.tx_data, 32'd0);
    chk("reset imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("reset imem_addr", bus.imem_addr, 32'd0);
    rst = 1'b0;

    // Commands before any LOAD: all answered with the error word
    for (int i = 0; i < 4; i++) begin
      set_halt(tbl[i].force_halt, tbl[i].k);
      do_cmd(tbl[i].word, tbl[i].ntx, tbl[i].en, tbl[i].last, $sformatf("vec%0d", i));
    end

    // Three-word LOAD with exact write/cpu_rst timing
    wr_q.delete();
    send_word(32'h0000_0001);
    @(negedge clk);
    send_word(32'h2001_0005);
    @(negedge clk);
    send_word(32'h2002_0007);
    @(negedge clk);
    send_word(32'h0000_0000);
    chk("load3 imem_we", {31'd0, bus.imem_we}, 32'd1);
    chk("load3 imem_addr", bus.imem_addr, 32'd2);
    chk("load3 imem_wdata", bus.imem_wdata, 32'd0);
    chk("load3 cpu_rst_still", {31'd0, bus.cpu_rst}, 32'd1);
    @(negedge clk);
    chk("load3 cpu_rst_fall", {31'd0, bus.cpu_rst}, 32'd0);
    chk("load3 busy", {31'd0, bus.busy}, 32'd0);
    chk("load3 wr_count", 32'(wr_q.size()), 32'd3);
    if (wr_q.size() == 3) begin
      chk("load3 w0", wr_q[0], {32'd0, 32'h2001_0005});
      chk("load3 w1", wr_q[1], {32'd1, 32'h2002_0007});
      chk("load3 w2", wr_q[2], {32'd2, 32'h0000_0000});
    end
    model_loaded = 1'b1;
    cnt_m = '0;

    // RUN / STEP / halted-on-entry / decode table
    for (int i = 4; i < 11; i++) begin
      set_halt(tbl[i].force_halt, tbl[i].k);
      do_cmd(tbl[i].word, tbl[i].ntx, tbl[i].en, tbl[i].last, $sformatf("vec%0d", i));
    end

    // Full-depth LOAD without a halt word, then the next word decodes as STEP
    prog_q.delete();
    for (int i = 0; i < 256; i++) prog_q.push_back($urandom() | 32'h1);
    do_load("load256");
    set_halt(1'b0, 0);
    do_cmd(32'h0000_0003, NTX, 1, 32'd1, "step_after_load");

    // Reset while dump word 20 waits for tx_done
    set_halt(1'b1, 0);
    repeat (2) @(negedge clk);
    tx_q.delete();
    hold_at = 21;
    send_word(32'h0000_0002);
    t = 0;
    while (tx_q.size() < 21 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rstmid reached_word20", 32'(tx_q.size()), 32'd21);
    repeat (2) @(negedge clk);
    chk("rstmid busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rstmid busy", {31'd0, bus.busy}, 32'd0);
    chk("rstmid cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
    rst = 1'b0;
    hold_at = -1;
    model_loaded = 1'b0;
    cnt_m = '0;
    do_cmd(32'h0000_0002, 1, 0, ERRW, "run_after_rst");

    // Randomized command mix against the bench model
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 3);
      tmp = $urandom();
      case (kind)
        0: begin
          prog_q.delete();
          k = $urandom_range(0, 4);
          for (int i = 0; i < k; i++) prog_q.push_back($urandom() | 32'h100);
          prog_q.push_back(32'h0);
          do_load($sformatf("rnd%0d load", it));
        end
        1: begin
          k = $urandom_range(0, 12);
          set_halt(k == 0, k);
          if (model_loaded)
            do_cmd({tmp[31:8], 8'h02}, NTX, k, cnt_m + 32'(k), $sformatf("rnd%0d run", it));
          else
            do_cmd({tmp[31:8], 8'h02}, 1, 0, ERRW, $sformatf("rnd%0d run", it));
        end
        2: begin
          k = $urandom_range(0, 1);
          set_halt(k == 1, 0);
          if (model_loaded)
            do_cmd({tmp[31:8], 8'h03}, NTX, 1 - k, cnt_m + 32'(1 - k), $sformatf("rnd%0d step", it));
          else
            do_cmd({tmp[31:8], 8'h03}, 1, 0, ERRW, $sformatf("rnd%0d step", it));
        end
        default: begin
          k = $urandom_range(4, 256);
          tmp[7:0] = 8'(k);
          do_cmd(tmp, 1, 0, ERRW, $sformatf("rnd%0d bad", it));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
